// File: rtl/finalprojectsoc_keys_pio.sv
// Avalon-MM input PIO: synchronises board keys/switches, exposes the live level,
// latches edges into a write-1-to-clear capture register and raises a maskable level IRQ.
module finalprojectsoc_keys_pio #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int PW        = $clog2(PRIME_MAX + 1);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_ff;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [PW-1:0]    prime_cnt;
  logic             primed;
  logic             wr_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] evt;
  logic [31:0]      rd_mux;
  reg_addr_e        reg_sel;

  assign sync_q  = sync_ff[SYNC_STAGES-1];
  assign primed  = (prime_cnt == PW'(PRIME_MAX));
  assign reg_sel = reg_addr_e'(address);
  assign wr_en   = chipselect & ~write_n;
  assign clr     = (wr_en && reg_sel == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign irq     = |(edgecapture & irqmask);

  // Edges are only trusted once the synchroniser and prev hold real input samples,
  // so a level held through reset never looks like a transition.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    evt = '0;
    if (primed) begin
      case (EDGE_TYPE)
        0:       evt = sync_q & ~prev;
        1:       evt = ~sync_q & prev;
        default: evt = (sync_q & ~prev) | (~sync_q & prev);
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      ADDR_DATA: rd_mux[WIDTH-1:0] = sync_q;
      ADDR_DIR:  rd_mux            = '0;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
      default:   rd_mux            = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff     <= '0;
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      prime_cnt   <= '0;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], in_port};
      prev     <= sync_q;
      readdata <= rd_mux;
      if (!primed) prime_cnt <= prime_cnt + PW'(1);
      if (wr_en && reg_sel == ADDR_MASK) irqmask <= writedata[WIDTH-1:0];
      // A new edge overrides a simultaneous clear so no event is ever lost.
      edgecapture <= evt | (edgecapture & ~clr);
    end
  end

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = |writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_finalprojectsoc_keys_pio.sv
// Bench for finalprojectsoc_keys_pio: falling-edge and any-edge instances share stimulus and
// are compared against a history-based model of the synchronised input waveform.
module tb_finalprojectsoc_keys_pio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_f, rd_a;
  logic        irq_f, irq_a;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  finalprojectsoc_keys_pio #(.WIDTH(4), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));

  finalprojectsoc_keys_pio #(.WIDTH(4), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  // Model: samp[j] is in_port as sampled at the (j+1)-th edge after reset. The bus-visible
  // level after edge k is the sample taken S-1 edges earlier; edges in that waveform are
  // ignored for the first S+1 edges after reset.
  logic [3:0]  samp[$];
  int          since;
  logic [3:0]  m_mask, m_cap_f, m_cap_a;
  logic [31:0] m_rd_f, m_rd_a;
  logic [3:0]  m_sq, m_old, m_rise, m_fall, m_clr;

  function automatic logic [3:0] vis(int k);
    int idx;
    idx = k - S + 1;
    if (idx >= 1 && idx <= samp.size()) return samp[idx-1];
    return 4'h0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      samp.delete();
      since   = 0;
      m_mask  = 4'h0;
      m_cap_f = 4'h0;
      m_cap_a = 4'h0;
      m_rd_f  = 32'h0;
      m_rd_a  = 32'h0;
    end else begin
      since  = since + 1;
      m_sq   = vis(since - 1);
      m_old  = vis(since - 2);
      m_rise = m_sq & ~m_old;
      m_fall = ~m_sq & m_old;
      if (since - 1 < S + 1) begin
        m_rise = 4'h0;
        m_fall = 4'h0;
      end
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      case (address)
        2'd0: begin m_rd_f = {28'h0, m_sq};    m_rd_a = {28'h0, m_sq};    end
        2'd1: begin m_rd_f = 32'h0;            m_rd_a = 32'h0;            end
        2'd2: begin m_rd_f = {28'h0, m_mask};  m_rd_a = {28'h0, m_mask};  end
        default: begin m_rd_f = {28'h0, m_cap_f}; m_rd_a = {28'h0, m_cap_a}; end
      endcase
      m_cap_f = m_fall | (m_cap_f & ~m_clr);
      m_cap_a = (m_rise | m_fall) | (m_cap_a & ~m_clr);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
      samp.push_back(in_port);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic read_reg(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; in_port = 4'hF;
    tick(3);
    reset = 1'b0;
    n_checks++;
    if (rd_f !== 32'h0 || irq_f !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: readdata=%h irq=%b required readdata=0 irq=0", rd_f, irq_f);
    end
    tick(8);
    bus_write(2'd2, 32'hF);
    read_reg(2'd3);
    n_checks++;
    if (rd_a !== 32'h0 || irq_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_spurious_edge: capture=%h irq=%b required 0/0", rd_a, irq_a);
    end
    read_reg(2'd0);
    n_checks++;
    if (rd_f !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL reset_level_read: got %h required 0000000f", rd_f);
    end
  endtask

  task automatic test_falling_capture;
    bus_write(2'd2, 32'h2);
    in_port = 4'b1101;
    tick(2);
    n_checks++;
    if (irq_f !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_latency_early: irq=%b required 0 at E0+1", irq_f);
    end
    tick();
    n_checks++;
    if (irq_f !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_irq: irq=%b required 1 at E0+2", irq_f);
    end
    read_reg(2'd3);
    n_checks++;
    if (rd_f !== 32'h2 || rd_a !== m_rd_a) begin
      n_fail++;
      $display("FAIL capture_read: fall=%h any=%h required 2 and %h", rd_f, rd_a, m_rd_a);
    end
  endtask

  task automatic test_w1c;
    bus_write(2'd3, 32'h2);
    n_checks++;
    if (irq_f !== 1'b0 || irq_a !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq_drop: irq_f=%b irq_a=%b required 0/0", irq_f, irq_a);
    end
    in_port = 4'hF;    tick(4);
    in_port = 4'b1101; tick(4);
    bus_write(2'd3, 32'h0);
    read_reg(2'd3);
    n_checks++;
    if (rd_f !== 32'h2 || irq_f !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_zero_keeps: capture=%h irq=%b required 2/1", rd_f, irq_f);
    end
  endtask

  task automatic test_set_beats_clear;
    in_port = 4'b1100; tick(4);
    in_port = 4'b1101; tick(4);
    in_port = 4'b1100;
    tick(2);
    bus_write(2'd3, 32'h1);
    read_reg(2'd3);
    n_checks++;
    if (rd_f !== 32'h3) begin
      n_fail++;
      $display("FAIL set_beats_clear: capture=%h required 3", rd_f);
    end
  endtask

  task automatic test_mask;
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
    in_port = 4'b0100;
    tick(4);
    read_reg(2'd3);
    n_checks++;
    if (rd_f !== 32'h8 || irq_f !== 1'b0) begin
      n_fail++;
      $display("FAIL masked_capture: capture=%h irq=%b required 8/0", rd_f, irq_f);
    end
    bus_write(2'd2, 32'h8);
    n_checks++;
    if (irq_f !== 1'b1) begin
      n_fail++;
      $display("FAIL unmask_irq: irq=%b required 1", irq_f);
    end
  endtask

  task automatic test_readonly_and_latency;
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd1, 32'hFFFFFFFF);
    read_reg(2'd1);
    n_checks++;
    if (rd_f !== 32'h0) begin
      n_fail++;
      $display("FAIL dir_read: got %h required 0", rd_f);
    end
    address = 2'd2;
    n_checks++;
    if (rd_f !== 32'h0) begin
      n_fail++;
      $display("FAIL latency_not_early: got %h required 0 before the edge", rd_f);
    end
    tick();
    n_checks++;
    if (rd_f !== 32'h8) begin
      n_fail++;
      $display("FAIL latency_one_cycle: mask read %h required 8", rd_f);
    end
    read_reg(2'd3);
    n_checks++;
    if (rd_f !== 32'h8 || irq_f !== 1'b1) begin
      n_fail++;
      $display("FAIL readonly_no_change: capture=%h irq=%b required 8/1", rd_f, irq_f);
    end
    read_reg(2'd0);
    n_checks++;
    if (rd_f !== 32'h4) begin
      n_fail++;
      $display("FAIL data_after_ro_write: got %h required 4", rd_f);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      n_checks++;
      if (rd_f !== m_rd_f || irq_f !== |(m_cap_f & m_mask)) begin
        n_fail++;
        $display("FAIL rand_fall cyc %0d: rd=%h irq=%b required rd=%h irq=%b",
                 i, rd_f, irq_f, m_rd_f, |(m_cap_f & m_mask));
      end
      n_checks++;
      if (rd_a !== m_rd_a || irq_a !== |(m_cap_a & m_mask)) begin
        n_fail++;
        $display("FAIL rand_any cyc %0d: rd=%h irq=%b required rd=%h irq=%b",
                 i, rd_a, irq_a, m_rd_a, |(m_cap_a & m_mask));
      end
      reset      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) in_port = 4'($urandom_range(0, 15));
      chipselect = $urandom_range(0, 1) == 1;
      write_n    = $urandom_range(0, 3) != 0;
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 4'hF;
    #1;
    test_reset;
    test_falling_capture;
    test_w1c;
    test_set_beats_clear;
    test_mask;
    test_readonly_and_latency;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
